cp0_int_timer: RTL and testbench

- Produces the 6-bit hardware interrupt vector consumed by the CP0 register block as its interrupt input (copied into Cause[15:10] each cycle).
- Holds the CP0 Count (reg 9) and Compare (reg 11) registers and raises the timer interrupt on int_o[5] (Cause IP7).
- Synchronises the asynchronous external interrupt pins onto int_o[4:0].
- Sits beside the CP0 register block: it receives the same MTC0/MFC0 write/read bus and provides the data for Count/Compare reads.

---
 rtl/cp0_int_timer.sv | 104 ++++++++++
 tb/tb_cp0_int_timer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_int_timer.sv
// CP0 Count/Compare timer and external interrupt synchroniser; drives the
// 6-bit hardware interrupt vector that the CP0 block copies into Cause.IP.
module cp0_int_timer #(
  parameter int EXT_NUM     = 5,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 2
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic [EXT_NUM-1:0] ext_int_i,
  input  logic               we,
  input  logic [4:0]         waddr,
  input  logic [31:0]        wdata,
  input  logic               re,
  input  logic [4:0]         raddr,
  output logic [31:0]        data_o,
  output logic               hit_o,
  output logic [5:0]         int_o
);

  localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;

  logic [PW-1:0]      presc;
  logic [31:0]        count;
  logic [31:0]        compare;
  logic               timer_pending;
  logic [EXT_NUM-1:0] sync_q [SYNC_STAGES];
  logic [4:0]         ext_vec;

  logic        inc;
  logic        count_wr;
  logic        compare_wr;
  logic [31:0] count_nxt;

  assign inc        = (presc == PRE_LAST);
  assign count_wr   = we && (waddr == REG_COUNT);
  assign compare_wr = we && (waddr == REG_COMPARE);
  assign count_nxt  = count + 32'd1;

  // A Count write restarts the prescaler and suppresses both increment and match.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      presc         <= '0;
      count         <= '0;
      compare       <= '0;
      timer_pending <= 1'b0;
    end else begin
      if (count_wr || inc)
        presc <= '0;
      else
        presc <= presc + PW'(1);

      if (count_wr)
        count <= wdata;
      else if (inc)
        count <= count_nxt;

      if (compare_wr)
        compare <= wdata;

      // Software clear wins over a match on the same edge; match uses old Compare.
      if (compare_wr)
        timer_pending <= 1'b0;
      else if (inc && !count_wr && (count_nxt == compare))
        timer_pending <= 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ext_int_i;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    ext_vec              = '0;
    ext_vec[EXT_NUM-1:0] = sync_q[SYNC_STAGES-1];
  end

  assign int_o = {timer_pending, ext_vec};

  always_comb begin
    data_o = '0;
    hit_o  = 1'b0;
    if (re && cpu_rst_n) begin
      if (raddr == REG_COUNT) begin
        data_o = count;
        hit_o  = 1'b1;
      end else if (raddr == REG_COMPARE) begin
        data_o = compare;
        hit_o  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp0_int_timer.sv
// Bench for cp0_int_timer: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of Count/Compare/pins.
module tb_cp0_int_timer;

  localparam int EXT_NUM     = 5;
  localparam int SYNC_STAGES = 2;
  localparam int PRESCALE    = 2;

  logic               cpu_clk_50M = 1'b0;
  logic               cpu_rst_n   = 1'b0;
  logic [EXT_NUM-1:0] ext_int_i   = '0;
  logic               we          = 1'b0;
  logic [4:0]         waddr       = '0;
  logic [31:0]        wdata       = '0;
  logic               re          = 1'b0;
  logic [4:0]         raddr       = '0;
  logic [31:0]        data_o;
  logic               hit_o;
  logic [5:0]         int_o;

  cp0_int_timer #(
    .EXT_NUM(EXT_NUM), .SYNC_STAGES(SYNC_STAGES), .PRESCALE(PRESCALE)
  ) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .ext_int_i(ext_int_i),
    .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .data_o(data_o), .hit_o(hit_o), .int_o(int_o)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0]        m_count, m_cmp;
  bit                 m_pend;
  int                 m_cyc;
  logic [EXT_NUM-1:0] hist [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = '0; m_cmp = '0; m_pend = 1'b0; m_cyc = 0;
    hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_front('0);
  endtask

  // Count advances once every PRESCALE cycles measured from reset or the last Count write.
  task automatic model_edge();
    bit          inc, cwr, kwr;
    logic [31:0] nxt;
    inc = ((m_cyc % PRESCALE) == PRESCALE - 1);
    cwr = we && (waddr == 5'd9);
    kwr = we && (waddr == 5'd11);
    nxt = m_count + 32'd1;
    if (kwr) m_pend = 1'b0;
    else if (inc && !cwr && nxt == m_cmp) m_pend = 1'b1;
    if (cwr) begin
      m_count = wdata; m_cyc = 0;
    end else begin
      if (inc) m_count = nxt;
      m_cyc++;
    end
    if (kwr) m_cmp = wdata;
    hist.push_front(ext_int_i);
    if (hist.size() > 8) void'(hist.pop_back());
  endtask

  task automatic model_check();
    logic [31:0] exp_d;
    logic        exp_h;
    logic [4:0]  exp_ext;
    exp_d = '0; exp_h = 1'b0; exp_ext = '0;
    if (re && raddr == 5'd9)  begin exp_d = m_count; exp_h = 1'b1; end
    if (re && raddr == 5'd11) begin exp_d = m_cmp;   exp_h = 1'b1; end
    exp_ext[EXT_NUM-1:0] = hist[SYNC_STAGES-1];
    chk("data_o", data_o, exp_d);
    chk("hit_o", {31'd0, hit_o}, {31'd0, exp_h});
    chk("int_o", {26'd0, int_o}, {26'd0, m_pend, exp_ext});
  endtask

  // Inputs change 1 time unit after an edge; outputs are checked mid-cycle.
  task automatic tick(input bit we_v, input logic [4:0] wa, input logic [31:0] wd,
                      input bit re_v, input logic [4:0] ra, input logic [EXT_NUM-1:0] ext_v);
    we = we_v; waddr = wa; wdata = wd; re = re_v; raddr = ra; ext_int_i = ext_v;
    #1;
    model_check();
    @(posedge cpu_clk_50M);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, ext_int_i);
  endtask

  task automatic do_reset();
    cpu_rst_n = 1'b0; we = 1'b0; re = 1'b0; ext_int_i = '0;
    model_reset();
    @(posedge cpu_clk_50M); @(posedge cpu_clk_50M);
    #1 cpu_rst_n = 1'b1;
  endtask

  // Runs idle cycles until int_o[5] rises; returns the edge count or -1 on timeout.
  task automatic wait_pend(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      idle(1);
      if (int_o[5]) begin edges = i; break; end
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    int  sel;
    do_reset();
    re = 1'b1; raddr = 5'd9; #1;
    chk("rst_int", {26'd0, int_o}, 32'd0);
    chk("rst_count", data_o, 32'd0);

    // 1: free run
    idle(20);
    re = 1'b1; raddr = 5'd9; #1;
    chk("t1_count_10", data_o, 32'd10);
    chk("t1_int_zero", {26'd0, int_o}, 32'd0);

    // 2: Compare=5, Count=0; pending after 10 edges and sticky
    tick(1'b1, 5'd11, 32'd5, 1'b0, 5'd0, '0);
    tick(1'b1, 5'd9, 32'd0, 1'b0, 5'd0, '0);
    wait_pend(40, n);
    chk("t2_edges_to_match", n, 32'd10);
    chk("t2_count_at_match", data_o, 32'd5);
    idle(6);
    chk("t2_sticky", {31'd0, int_o[5]}, 32'd1);

    // 3a: Compare write clears pending next cycle
    tick(1'b1, 5'd11, 32'h20, 1'b0, 5'd0, '0);
    chk("t3_clear", {31'd0, int_o[5]}, 32'd0);
    // 3b: Compare write landing on the match edge wins
    tick(1'b1, 5'd11, 32'd5, 1'b0, 5'd0, '0);
    tick(1'b1, 5'd9, 32'd0, 1'b0, 5'd0, '0);
    idle(9);
    tick(1'b1, 5'd11, 32'h100, 1'b1, 5'd9, '0);
    seen = int_o[5];
    for (int i = 0; i < 6; i++) begin idle(1); seen |= int_o[5]; end
    chk("t3_no_pend", {31'd0, seen}, 32'd0);

    // 4: wrap through 0xFFFFFFFF to 0 with Compare=0
    tick(1'b1, 5'd11, 32'd0, 1'b0, 5'd0, '0);
    tick(1'b1, 5'd9, 32'hFFFF_FFFE, 1'b0, 5'd0, '0);
    idle(2);
    chk("t4_ffff", data_o, 32'hFFFF_FFFF);
    wait_pend(20, n);
    chk("t4_wrap_edges", n, 32'd2);
    chk("t4_wrap_zero", data_o, 32'd0);
    tick(1'b1, 5'd11, 32'd0, 1'b0, 5'd0, '0);
    tick(1'b1, 5'd9, 32'd0, 1'b0, 5'd0, '0);
    chk("t4_wr_eq_nopend", {31'd0, int_o[5]}, 32'd0);

    // 5: external pin 2 latency
    tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'b00100);
    chk("t5_rise_e1", {27'd0, int_o[4:0]}, 32'd0);
    tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'b00100);
    chk("t5_rise_e2", {27'd0, int_o[4:0]}, 32'b00100);
    tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'b00000);
    chk("t5_fall_e1", {27'd0, int_o[4:0]}, 32'b00100);
    tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'b00000);
    chk("t5_fall_e2", {27'd0, int_o[4:0]}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: tick(1'b1, 5'd9,  (($urandom_range(0,3) == 0) ? 32'hFFFF_FFFC : 32'd0) + $urandom_range(0,3),
                1'b1, 5'($urandom), 5'($urandom));
        1: tick(1'b1, 5'd11, m_count + $urandom_range(0, 6), 1'b1, 5'd11, 5'($urandom));
        2: tick(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), 5'($urandom));
        default: tick(1'b0, 5'd0, 32'd0, 1'($urandom), (($urandom_range(0,1) == 0) ? 5'd9 : 5'd11),
                      ($urandom_range(0,3) == 0) ? 5'($urandom) : ext_int_i);
      endcase
    end

    // 6: async reset mid-cycle with pending and Count=0x1234
    tick(1'b1, 5'd11, 32'h1236, 1'b0, 5'd0, 5'b11111);
    tick(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 5'b11111);
    wait_pend(10, n);
    chk("t6_pend_set", {31'd0, int_o[5]}, 32'd1);
    #3 cpu_rst_n = 1'b0;
    re = 1'b1; raddr = 5'd9; #1;
    chk("t6_int_zero", {26'd0, int_o}, 32'd0);
    chk("t6_count_zero", data_o, 32'd0);
    chk("t6_hit_in_rst", {31'd0, hit_o}, 32'd0);
    raddr = 5'd12; #1;
    chk("t6_r12_data", data_o, 32'd0);
    chk("t6_r12_hit", {31'd0, hit_o}, 32'd0);
    cpu_rst_n = 1'b1; raddr = 5'd11; #1;
    chk("t6_cmp_zero", data_o, 32'd0);
    do_reset();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
